// File: rtl/ldpc_llr_loader_if.sv
// ---------------------------------------------------------------------------
// ldpc_llr_loader_if
// Channel-LLR sample stream into the LDPC LLR loader, with a valid/ready
// handshake.
//   llr_in    : two's-complement LLR sample, IN_WIDTH bits (source -> loader)
//   llr_valid : llr_in / llr_sof are valid                  (source -> loader)
//   llr_sof   : first sample of a frame, qualified by valid (source -> loader)
//   llr_ready : loader can accept a sample                  (loader -> source)
// Modports: master = sample source, slave = loader.
// ---------------------------------------------------------------------------
interface ldpc_llr_loader_if #(
  parameter int IN_WIDTH = 6
);
  logic [IN_WIDTH-1:0] llr_in;
  logic                llr_valid;
  logic                llr_sof;
  logic                llr_ready;

  modport master (output llr_in, output llr_valid, output llr_sof, input  llr_ready);
  modport slave  (input  llr_in, input  llr_valid, input  llr_sof, output llr_ready);
endinterface

// File: rtl/ldpc_llr_loader.sv
// ---------------------------------------------------------------------------
// ldpc_llr_loader
// Input stage of the LDPC decoder. Takes signed channel LLR samples from the
// stream interface, saturates each one symmetrically to WIDTH bits and writes
// one frame of FRAME_LEN words into the LLR RAM (active-low write enable).
// After the last word the frame is held (llr_ready low) until the decoder
// pulses frame_release; the next frame can then start.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   llr_if        : sample stream (slave side): llr_in/llr_valid/llr_sof/llr_ready
//   we            : RAM write enable, active-low, registered
//   din, wraddr   : RAM write data / address, registered, hold when idle
//   frame_done    : one-cycle pulse with the last word's write
//   frame_err     : one-cycle pulse with a word-0 write caused by a mid-frame sof
//   busy          : high while loading or holding a frame
//   frame_release : decoder has finished with the buffered frame
//   sat_count     : saturated samples in the current/last frame
//
// Optional feature: define LDPC_LLR_SAT_COUNT_EN to build the saturation
// counter; otherwise sat_count is tied to zero.
// ---------------------------------------------------------------------------
module ldpc_llr_loader #(
  parameter int IN_WIDTH  = 6,
  parameter int WIDTH     = 4,
  parameter int LOG2DEPTH = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ldpc_llr_loader_if.slave       llr_if,
  output logic                   we,
  output logic [WIDTH-1:0]       din,
  output logic [LOG2DEPTH-1:0]   wraddr,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   busy,
  input  logic                   frame_release,
  output logic [LOG2DEPTH:0]     sat_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Symmetric clamp limits: the most negative code is never produced.
  localparam logic signed [IN_WIDTH-1:0]  SAT_MAX   = IN_WIDTH'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0]  SAT_MIN   = -SAT_MAX;
  localparam logic [LOG2DEPTH-1:0]        LAST_ADDR = LOG2DEPTH'(FRAME_LEN - 1);
  localparam logic [LOG2DEPTH-1:0]        ADDR_ZERO = {LOG2DEPTH{1'b0}};

  // Clamp to [SAT_MIN, SAT_MAX], then truncate to the RAM word width.
  function automatic logic [WIDTH-1:0] sat_llr(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH-1:0] c;
    if (x > SAT_MAX) begin
      c = SAT_MAX;
    end else if (x < SAT_MIN) begin
      c = SAT_MIN;
    end else begin
      c = x;
    end
    return WIDTH'(c);
  endfunction

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     din_q, din_d;
  logic [LOG2DEPTH-1:0] wraddr_q, wraddr_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 ready_s;
  logic                 xfer_s;
  logic                 wr_en_s;     // a sample is written this edge
  logic                 wr_first_s;  // that write is word 0 of a frame

  // Ready comes from the state register alone, never from llr_valid.
  assign ready_s          = (state_q != ST_FULL);
  assign llr_if.llr_ready = ready_s;
  assign xfer_s           = llr_if.llr_valid & ready_s;

  // Next-state and registered-output logic of the loader FSM.
  always_comb begin
    state_d      = state_q;
    we_d         = 1'b1;
    din_d        = din_q;
    wraddr_d     = wraddr_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    wr_en_s      = 1'b0;
    wr_first_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Samples without sof are consumed and dropped.
        if (xfer_s && llr_if.llr_sof) begin
          wr_en_s    = 1'b1;
          wr_first_s = 1'b1;
          we_d       = 1'b0;
          din_d      = sat_llr(llr_if.llr_in);
          wraddr_d   = ADDR_ZERO;
          if (FRAME_LEN == 1) begin
            state_d      = ST_FULL;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          wr_en_s = 1'b1;
          we_d    = 1'b0;
          din_d   = sat_llr(llr_if.llr_in);
          if (llr_if.llr_sof) begin
            // Mid-frame sof abandons the partial frame and restarts at 0.
            wr_first_s  = 1'b1;
            wraddr_d    = ADDR_ZERO;
            frame_err_d = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            // wraddr_q is the last address written in this frame.
            wraddr_d = wraddr_q + LOG2DEPTH'(1);
            if (wraddr_d == LAST_ADDR) begin
              state_d      = ST_FULL;
              frame_done_d = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FULL: begin
        if (frame_release) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b1;
      din_q        <= {WIDTH{1'b0}};
      wraddr_q     <= ADDR_ZERO;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      din_q        <= din_d;
      wraddr_q     <= wraddr_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign we         = we_q;
  assign din        = din_q;
  assign wraddr     = wraddr_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef LDPC_LLR_SAT_COUNT_EN
  logic [LOG2DEPTH:0] sat_count_q, sat_count_d;
  logic               sat_hit_s;

  assign sat_hit_s = ($signed(llr_if.llr_in) > SAT_MAX) || ($signed(llr_if.llr_in) < SAT_MIN);

  // Count clamped samples; word 0 of each frame restarts the count.
  always_comb begin
    sat_count_d = sat_count_q;
    if (wr_first_s) begin
      sat_count_d = {LOG2DEPTH'(0), sat_hit_s};
    end else if (wr_en_s) begin
      sat_count_d = sat_count_q + {LOG2DEPTH'(0), sat_hit_s};
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= {(LOG2DEPTH + 1){1'b0}};
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = {(LOG2DEPTH + 1){1'b0}};
`endif

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// ---------------------------------------------------------------------------
// tb_ldpc_llr_loader
// Self-checking bench for ldpc_llr_loader: directed scenarios followed by
// random traffic, every cycle compared against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_ldpc_llr_loader;
  localparam int IN_WIDTH  = 6;
  localparam int WIDTH     = 4;
  localparam int LOG2DEPTH = 4;
  localparam int FRAME_LEN = 16;
  localparam int MAXV      = (2 ** (WIDTH - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  logic we;
  logic [WIDTH-1:0] din;
  logic [LOG2DEPTH-1:0] wraddr;
  logic frame_done, frame_err, busy, frame_release;
  logic [LOG2DEPTH:0] sat_count;

  ldpc_llr_loader_if #(.IN_WIDTH(IN_WIDTH)) llr_if ();

  ldpc_llr_loader #(
    .IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .LOG2DEPTH(LOG2DEPTH), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rst(rst), .llr_if(llr_if),
    .we(we), .din(din), .wraddr(wraddr),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy),
    .frame_release(frame_release), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 = waiting for sof, 1 = filling, 2 = holding.
  int m_phase, m_count, m_sat;
  int exp_we, exp_din, exp_addr, exp_done, exp_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  function automatic int to_word(input int v);
    return v & ((1 << WIDTH) - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_sat = 0;
    exp_we = 1; exp_din = 0; exp_addr = 0; exp_done = 0; exp_err = 0;
  endtask

  // Apply one rising edge to the model with the inputs that were present.
  task automatic model_edge(input bit v, input bit s, input int x, input bit rl);
    bit rdy;
    rdy = (m_phase != 2);
    exp_we = 1; exp_done = 0; exp_err = 0;
    if (v && rdy) begin
      if (s) begin
        exp_err = (m_phase == 1) ? 1 : 0;
        m_count = 0;
        m_sat   = 0;
      end
      if (s || m_phase == 1) begin
        exp_we   = 0;
        exp_addr = m_count;
        exp_din  = to_word(clamp(x));
        if (clamp(x) != x) m_sat++;
        m_count++;
        if (m_count == FRAME_LEN) begin
          m_phase  = 2;
          exp_done = 1;
        end else begin
          m_phase = 1;
        end
      end
    end else if (m_phase == 2 && rl) begin
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    int exp_sat;
`ifdef LDPC_LLR_SAT_COUNT_EN
    exp_sat = m_sat;
`else
    exp_sat = 0;
`endif
    check_val("we", 32'(we), exp_we);
    check_val("din", 32'(din), exp_din);
    check_val("wraddr", 32'(wraddr), exp_addr);
    check_val("frame_done", 32'(frame_done), exp_done);
    check_val("frame_err", 32'(frame_err), exp_err);
    check_val("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
    check_val("llr_ready", 32'(llr_if.llr_ready), (m_phase != 2) ? 1 : 0);
    check_val("sat_count", 32'(sat_count), exp_sat);
  endtask

  // Drive one cycle of inputs (called at the falling edge), then check.
  task automatic step(input bit v, input bit s, input int x, input bit rl);
    llr_if.llr_valid = v;
    llr_if.llr_sof   = s;
    llr_if.llr_in    = IN_WIDTH'(x);
    frame_release    = rl;
    @(posedge clk);
    model_edge(v, s, x, rl);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic release_frame();
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int sat_vals [4] = '{20, -8, -32, 7};
    rst = 1'b1;
    llr_if.llr_valid = 1'b0;
    llr_if.llr_sof   = 1'b0;
    llr_if.llr_in    = '0;
    frame_release    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Back-to-back frame 0..15, stall while full, then release.
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, i == 0, i, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);

    // Saturation at the frame start, rest of the frame in range.
    for (int i = 0; i < FRAME_LEN; i++)
      step(1'b1, i == 0, (i < 4) ? sat_vals[i] : i - 8, 1'b0);
    release_frame();

    // Samples without sof while idle, then a restart at sample 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, i + 1, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, i == 0, -i, 1'b0);
    release_frame();

    // Valid every other cycle.
    for (int i = 0; i < 2 * FRAME_LEN; i++) step(i % 2 == 0, i == 0, i - 12, 1'b0);
    release_frame();

    // Asynchronous reset after word 7 has been written.
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, i, 1'b0);
    llr_if.llr_valid = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, i == 0, 9 - i, 1'b0);
    release_frame();

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(3) != 0, $urandom_range(19) == 0,
           int'($urandom_range(63)) - 32, $urandom_range(3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
